// File: rtl/btn_cmd_tx_queue.sv
// btn_cmd_tx_queue
//
// Turns debounced single-cycle button pulses into ASCII command bytes for a
// UART transmitter. Each press sets a pending bit. The lowest pending button
// is moved into a small FIFO, and the FIFO head is handed to the UART through
// a start/busy handshake.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   i_btn_pulse  one-cycle press pulses, bit n = button n
//   i_tx_busy    UART TX busy, high while a frame is shifting
//   o_tx_data    byte being transmitted, held until the next pop
//   o_tx_start   one-cycle start strobe to the UART TX
//   o_full       FIFO full (registered)
//   o_empty      FIFO empty (registered)
//   o_drop_cnt   saturating count of presses lost on a busy pending bit
//
// Optional feature macro: BTN_CMD_CRLF_EN
//   When defined, every command byte is followed by CR (8'h0D) and then
//   LF (8'h0A). Both use the same handshake, and neither is stored in the FIFO.
module btn_cmd_tx_queue #(
    parameter int          NUM_BTN      = 4,
    parameter int          DEPTH        = 4,
    parameter logic [7:0]  CHAR_0       = 8'h55,
    parameter logic [7:0]  CHAR_1       = 8'h44,
    parameter logic [7:0]  CHAR_2       = 8'h4C,
    parameter logic [7:0]  CHAR_3       = 8'h52,
    parameter int          BUSY_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] i_btn_pulse,
    input  logic               i_tx_busy,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic               o_full,
    output logic               o_empty,
    output logic [7:0]         o_drop_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int DW = $clog2(NUM_BTN + 1);

`ifdef BTN_CMD_CRLF_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BUSY, S_WAIT_DONE, S_SEND_CR, S_SEND_LF
    } state_t;
    localparam logic [1:0] PH_CMD = 2'd0;
    localparam logic [1:0] PH_CR  = 2'd1;
    localparam logic [1:0] PH_LF  = 2'd2;
    logic [1:0] phase, phase_nxt;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_WAIT_BUSY, S_WAIT_DONE
    } state_t;
`endif

    function automatic logic [7:0] char_of(input int idx);
        case (idx)
            0:       char_of = CHAR_0;
            1:       char_of = CHAR_1;
            2:       char_of = CHAR_2;
            default: char_of = CHAR_3;
        endcase
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [DW-1:0] n);
        logic [8:0] s;
        s = {1'b0, a} + 9'(n);
        sat_add = s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [NUM_BTN-1:0] pending, pend_low, pend_clr, drops;
    logic [7:0]         mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count, count_nxt;
    logic [7:0]         push_char, data_nxt;
    logic [DW-1:0]      drop_n;
    logic               push, pop, load, start_nxt;
    state_t             state, state_nxt, byte_done_state;
    logic [TW-1:0]      tcnt, tcnt_nxt;

    // Pending capture and push selection. The lowest set pending bit is
    // isolated with the two's-complement trick.
    always_comb begin
        pend_low  = pending & (~pending + NUM_BTN'(1));
        push      = (|pending) && (!o_full || pop);
        pend_clr  = push ? pend_low : '0;
        // A pulse on a bit being pushed this cycle simply re-arms it.
        drops     = i_btn_pulse & pending & ~pend_clr;
        drop_n    = DW'($countones(drops));
        push_char = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (pend_low[i]) push_char = char_of(i);
        end
        count_nxt = count + CW'(push) - CW'(pop);
    end

    // Handshake FSM: next state and strobes.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        pop       = 1'b0;
        load      = 1'b0;
        start_nxt = 1'b0;
        data_nxt  = mem[rd_ptr];
`ifdef BTN_CMD_CRLF_EN
        phase_nxt = phase;
        if (phase == PH_CMD)     byte_done_state = S_SEND_CR;
        else if (phase == PH_CR) byte_done_state = S_SEND_LF;
        else                     byte_done_state = S_IDLE;
`else
        byte_done_state = S_IDLE;
`endif
        case (state)
            S_IDLE: begin
                if (!o_empty && !i_tx_busy) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    start_nxt = 1'b1;
                    tcnt_nxt  = '0;
                    state_nxt = S_WAIT_BUSY;
`ifdef BTN_CMD_CRLF_EN
                    phase_nxt = PH_CMD;
`endif
                end
            end
            S_WAIT_BUSY: begin
                // A UART that never raises busy is treated as having sent the byte.
                if (i_tx_busy)                              state_nxt = S_WAIT_DONE;
                else if (tcnt == TW'(BUSY_TIMEOUT - 1))     state_nxt = byte_done_state;
                else                                        tcnt_nxt  = tcnt + 1'b1;
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) state_nxt = byte_done_state;
            end
`ifdef BTN_CMD_CRLF_EN
            S_SEND_CR: begin
                if (!i_tx_busy) begin
                    load      = 1'b1;
                    data_nxt  = 8'h0D;
                    start_nxt = 1'b1;
                    tcnt_nxt  = '0;
                    phase_nxt = PH_CR;
                    state_nxt = S_WAIT_BUSY;
                end
            end
            S_SEND_LF: begin
                if (!i_tx_busy) begin
                    load      = 1'b1;
                    data_nxt  = 8'h0A;
                    start_nxt = 1'b1;
                    tcnt_nxt  = '0;
                    phase_nxt = PH_LF;
                    state_nxt = S_WAIT_BUSY;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            tcnt  <= '0;
`ifdef BTN_CMD_CRLF_EN
            phase <= PH_CMD;
`endif
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
`ifdef BTN_CMD_CRLF_EN
            phase <= phase_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_full     <= 1'b0;
            o_empty    <= 1'b1;
            o_drop_cnt <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            pending    <= (pending & ~pend_clr) | i_btn_pulse;
            count      <= count_nxt;
            o_full     <= (count_nxt == CW'(DEPTH));
            o_empty    <= (count_nxt == '0);
            o_drop_cnt <= sat_add(o_drop_cnt, drop_n);
            o_tx_start <= start_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (load) o_tx_data <= data_nxt;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_char;
    end

endmodule

// File: doc/btn_cmd_tx_queue.md
Name: btn_cmd_tx_queue

Overview:
Downstream consumer of the debounced single-cycle button pulses (one pulse per press, one per button).
- Latches presses from up to 4 buttons, maps each to an ASCII command byte and buffers the bytes in a small FIFO.
- Issues the bytes one at a time to the UART transmitter through a start/busy handshake.
- Sits between the per-button debounce instances and uart_tx in the UART top level.

Parameters:
- NUM_BTN, 4, number of button pulse inputs (fixed 4 in this revision).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CHAR_0, 8'h55, byte for button 0 ('U').
- CHAR_1, 8'h44, byte for button 1 ('D').
- CHAR_2, 8'h4C, byte for button 2 ('L').
- CHAR_3, 8'h52, byte for button 3 ('R').
- BUSY_TIMEOUT, 4, cycles to wait for i_tx_busy to rise after o_tx_start.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-high reset.
- i_btn_pulse  input  4  one-cycle press pulses; bit n = button n.
- i_tx_busy  input  1  UART TX busy; high while a frame is shifting.
- o_tx_data  output  8  byte to transmit; stable from o_tx_start until busy falls.
- o_tx_start  output  1  one-cycle start strobe to the UART TX.
- o_full  output  1  FIFO full.
- o_empty  output  1  FIFO empty.
- o_drop_cnt  output  8  saturating count of lost presses.

Behaviour:
- One clock domain. Reset is synchronous, active-high, sampled on posedge clk.
- Reset values: pending=0, FIFO ptrs/count=0, o_tx_data=0, o_tx_start=0, o_full=0, o_empty=1, o_drop_cnt=0, FSM=IDLE.
- Reset mid-transfer aborts immediately: FIFO contents discarded, no further start strobe.
- Pending capture: pending[n] is set on i_btn_pulse[n].
  - If pending[n] is already 1 when a new pulse on n arrives, the press is lost and o_drop_cnt increments; it saturates at 255.
  - Several simultaneous lost presses in one cycle add their number (saturating).
- Push: each cycle, if any pending bit is set and the FIFO can accept, push CHAR_k for the lowest set index k and clear pending[k] in the same cycle.
  - A pulse arriving on k in that same cycle re-sets pending[k]. This is not a drop.
  - "Can accept" = !full OR pop in the same cycle. Simultaneous push and pop on a full FIFO leaves the count unchanged.
- Latency: a pulse at cycle t is pushed at edge t+1 (FIFO empty, no lower-index pending). o_tx_start is asserted at t+2 if the FSM is IDLE and i_tx_busy=0.
- Pointers wrap modulo DEPTH.
- o_full / o_empty are registered and reflect the count after the edge.
- FSM states:
  - IDLE: if !empty && !i_tx_busy, pop the head into o_tx_data, pulse o_tx_start for 1 cycle, go to WAIT_BUSY; else stay.
  - WAIT_BUSY: if i_tx_busy=1, go to WAIT_DONE. Else count cycles; after BUSY_TIMEOUT cycles with no busy, go to IDLE (byte considered sent).
  - WAIT_DONE: when i_tx_busy=0, go to IDLE.
- o_tx_start is never asserted outside the IDLE→WAIT_BUSY transition. It is never asserted while i_tx_busy=1.
- o_tx_data holds its value until the next pop.

Optional Feature:
Macro: BTN_CMD_CRLF_EN
- Defined:
  - After each popped command byte completes (WAIT_DONE→done, or timeout), the FSM sends 8'h0D, then 8'h0A.
  - Each uses the same start/WAIT_BUSY/WAIT_DONE handshake, via extra states SEND_CR and SEND_LF.
  - CR/LF are not stored in the FIFO. The next FIFO pop waits until LF completes.
- Not defined: one UART byte per press; no CR/LF states are synthesized.

Test Plan:
- Reset, then single pulse on bit 0 at cycle 10, i_tx_busy model high 3 cycles after start:
  - o_tx_start high at cycle 12 only, o_tx_data=8'h55.
  - o_empty returns to 1; o_drop_cnt=0.
- i_btn_pulse=4'b1111 in one cycle, busy model 20 cycles per byte:
  - bytes sent in order 55,44,4C,52; exactly 4 starts; no drops.
- Hold i_tx_busy=1, pulse button 2 nine times with 2-cycle spacing:
  - FIFO fills (o_full=1 after 4 pushes), pending[2] holds the 5th press, 4 later presses lost → o_drop_cnt=4.
  - On releasing busy, 5 bytes 8'h4C are sent.
- i_tx_busy stuck 0 (no UART response), one press:
  - one start strobe; FSM returns to IDLE after 4 cycles; the next press produces a new start.
- Reset asserted in WAIT_DONE with 3 bytes queued:
  - next cycle all outputs are at reset values; no start strobe until a new press.
- With BTN_CMD_CRLF_EN, one press on button 3:
  - three starts with data 52, 0D, 0A in order, each after busy falls.
